// File: rtl/int_issue_queue.sv
// rtl/int_issue_queue.sv - integer issue queue: age-ordered entries, CDB wakeup, oldest-ready issue
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OPC_W  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              dispatch_valid,
  input  logic [OPC_W-1:0]  dispatch_opcode,
  input  logic [TAG_W-1:0]  dispatch_rd_tag,
  input  logic              dispatch_rs1_valid,
  input  logic              dispatch_rs2_valid,
  input  logic [TAG_W-1:0]  dispatch_rs1_tag,
  input  logic [TAG_W-1:0]  dispatch_rs2_tag,
  input  logic [DATA_W-1:0] dispatch_rs1_data,
  input  logic [DATA_W-1:0] dispatch_rs2_data,
  output logic              queue_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              ready_int,
  input  logic              issue_int,
  output logic [OPC_W-1:0]  issue_opcode,
  output logic [TAG_W-1:0]  issue_rd_tag,
  output logic [DATA_W-1:0] issue_rs1_data,
  output logic [DATA_W-1:0] issue_rs2_data,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic              busy;
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  rd;
    logic              v1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] d1;
    logic              v2;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] d2;
  } entry_t;

  entry_t q      [DEPTH];
  entry_t q_up   [DEPTH];
  entry_t s      [DEPTH];
  entry_t n      [DEPTH];
  entry_t disp_e;

  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             do_issue;
  logic             accept;
  logic [CNT_W-1:0] wr_idx;
  logic             byp1;
  logic             byp2;

  // q_up[i] is the entry that slides into slot i when an older entry issues
  for (genvar g = 0; g < DEPTH - 1; g++) begin : g_up
    assign q_up[g] = q[g + 1];
  end
  assign q_up[DEPTH-1] = '0;

  // Scanning downward leaves the lowest-index (oldest) ready entry selected
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (q[i].busy && q[i].v1 && q[i].v2) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end

  assign ready_int      = sel_found;
  assign issue_opcode   = sel_found ? q[sel_idx].opc : '0;
  assign issue_rd_tag   = sel_found ? q[sel_idx].rd  : '0;
  assign issue_rs1_data = sel_found ? q[sel_idx].d1  : '0;
  assign issue_rs2_data = sel_found ? q[sel_idx].d2  : '0;

  assign queue_full = (count == CNT_W'(DEPTH));
  assign do_issue   = issue_int & sel_found;
  assign accept     = dispatch_valid & ~queue_full;
  assign wr_idx     = count - CNT_W'(do_issue);

  assign byp1 = ~dispatch_rs1_valid & cdb_valid & (dispatch_rs1_tag == cdb_tag);
  assign byp2 = ~dispatch_rs2_valid & cdb_valid & (dispatch_rs2_tag == cdb_tag);

  always_comb begin
    disp_e      = '0;
    disp_e.busy = 1'b1;
    disp_e.opc  = dispatch_opcode;
    disp_e.rd   = dispatch_rd_tag;
    disp_e.v1   = dispatch_rs1_valid | byp1;
    disp_e.t1   = dispatch_rs1_tag;
    disp_e.d1   = dispatch_rs1_valid ? dispatch_rs1_data : (byp1 ? cdb_data : '0);
    disp_e.v2   = dispatch_rs2_valid | byp2;
    disp_e.t2   = dispatch_rs2_tag;
    disp_e.d2   = dispatch_rs2_valid ? dispatch_rs2_data : (byp2 ? cdb_data : '0);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      s[i] = (do_issue && (IDX_W'(i) >= sel_idx)) ? q_up[i] : q[i];
    end
  end

  // Wakeup is applied after the shift so the issued entry's wakeup is dropped
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      n[i] = s[i];
      if (cdb_valid && s[i].busy && !s[i].v1 && (s[i].t1 == cdb_tag)) begin
        n[i].v1 = 1'b1;
        n[i].d1 = cdb_data;
      end
      if (cdb_valid && s[i].busy && !s[i].v2 && (s[i].t2 == cdb_tag)) begin
        n[i].v2 = 1'b1;
        n[i].d2 = cdb_data;
      end
      if (accept && (CNT_W'(i) == wr_idx)) begin
        n[i] = disp_e;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) q[i] <= n[i];
      count <= count - CNT_W'(do_issue) + CNT_W'(accept);
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// tb/tb_int_issue_queue.sv - randomized and directed bench for int_issue_queue against a queue model
module tb_int_issue_queue;
  localparam int DEPTH = 4, DATA_W = 32, TAG_W = 6, OPC_W = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst, flush, dispatch_valid, dispatch_rs1_valid, dispatch_rs2_valid;
  logic [OPC_W-1:0]  dispatch_opcode;
  logic [TAG_W-1:0]  dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag, cdb_tag;
  logic [DATA_W-1:0] dispatch_rs1_data, dispatch_rs2_data, cdb_data;
  logic cdb_valid, issue_int, queue_full, ready_int;
  logic [OPC_W-1:0]  issue_opcode;
  logic [TAG_W-1:0]  issue_rd_tag;
  logic [DATA_W-1:0] issue_rs1_data, issue_rs2_data;
  logic [CNT_W-1:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OPC_W(OPC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
    .dispatch_rd_tag(dispatch_rd_tag),
    .dispatch_rs1_valid(dispatch_rs1_valid), .dispatch_rs2_valid(dispatch_rs2_valid),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
    .dispatch_rs1_data(dispatch_rs1_data), .dispatch_rs2_data(dispatch_rs2_data),
    .queue_full(queue_full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ready_int(ready_int), .issue_int(issue_int), .issue_opcode(issue_opcode),
    .issue_rd_tag(issue_rd_tag), .issue_rs1_data(issue_rs1_data),
    .issue_rs2_data(issue_rs2_data), .count(count)
  );

  typedef struct {
    logic [OPC_W-1:0]  opc;
    logic [TAG_W-1:0]  rd;
    logic              v1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] d1;
    logic              v2;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] d2;
  } ent_t;

  ent_t mq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_sel();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].v1 && mq[i].v2) return i;
    return -1;
  endfunction

  task automatic compare();
    int s;
    s = model_sel();
    check("count", 64'(count), 64'(mq.size()));
    check("queue_full", 64'(queue_full), 64'(mq.size() == DEPTH));
    check("ready_int", 64'(ready_int), 64'(s >= 0));
    if (s >= 0) begin
      check("issue_opcode", 64'(issue_opcode), 64'(mq[s].opc));
      check("issue_rd_tag", 64'(issue_rd_tag), 64'(mq[s].rd));
      check("issue_rs1_data", 64'(issue_rs1_data), 64'(mq[s].d1));
      check("issue_rs2_data", 64'(issue_rs2_data), 64'(mq[s].d2));
    end else begin
      check("idle_outputs", {issue_opcode, issue_rd_tag, issue_rs1_data[7:0], issue_rs2_data}, 64'd0);
      check("idle_rs1", 64'(issue_rs1_data), 64'd0);
    end
  endtask

  task automatic model_step();
    int s;
    bit full;
    ent_t e;
    if (!rst || flush) begin
      mq.delete();
      return;
    end
    s = model_sel();
    full = (mq.size() == DEPTH);
    if (issue_int && s >= 0) mq.delete(s);
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].v1 && mq[i].t1 == cdb_tag) begin mq[i].v1 = 1'b1; mq[i].d1 = cdb_data; end
        if (!mq[i].v2 && mq[i].t2 == cdb_tag) begin mq[i].v2 = 1'b1; mq[i].d2 = cdb_data; end
      end
    end
    if (dispatch_valid && !full) begin
      e.opc = dispatch_opcode;
      e.rd  = dispatch_rd_tag;
      e.t1  = dispatch_rs1_tag;
      e.t2  = dispatch_rs2_tag;
      e.v1  = dispatch_rs1_valid;
      e.d1  = dispatch_rs1_data;
      e.v2  = dispatch_rs2_valid;
      e.d2  = dispatch_rs2_data;
      if (!e.v1 && cdb_valid && cdb_tag == e.t1) begin e.v1 = 1'b1; e.d1 = cdb_data; end
      if (!e.v2 && cdb_valid && cdb_tag == e.t2) begin e.v2 = 1'b1; e.d2 = cdb_data; end
      mq.push_back(e);
    end
  endtask

  task automatic cycle();
    compare();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    rst = 1'b1; flush = 1'b0; dispatch_valid = 1'b0; cdb_valid = 1'b0; issue_int = 1'b0;
    dispatch_opcode = '0; dispatch_rd_tag = '0;
    dispatch_rs1_valid = 1'b0; dispatch_rs1_tag = '0; dispatch_rs1_data = '0;
    dispatch_rs2_valid = 1'b0; dispatch_rs2_tag = '0; dispatch_rs2_data = '0;
    cdb_tag = '0; cdb_data = '0;
  endtask

  task automatic disp(input int opc, input int rd, input bit v1, input int t1, input int d1,
                      input bit v2, input int t2, input int d2);
    dispatch_valid = 1'b1;
    dispatch_opcode = OPC_W'(opc); dispatch_rd_tag = TAG_W'(rd);
    dispatch_rs1_valid = v1; dispatch_rs1_tag = TAG_W'(t1); dispatch_rs1_data = DATA_W'(d1);
    dispatch_rs2_valid = v2; dispatch_rs2_tag = TAG_W'(t2); dispatch_rs2_data = DATA_W'(d2);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    mq.delete();
    #1;
    rst = 1'b1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(queue_full), 64'd0);
    check("rst_ready", 64'(ready_int), 64'd0);

    // simple dispatch and issue
    disp(3, 5, 1, 0, 10, 1, 0, 20);
    cycle();
    idle();
    check("t1_ready", 64'(ready_int), 64'd1);
    check("t1_rs1", 64'(issue_rs1_data), 64'd10);
    check("t1_rs2", 64'(issue_rs2_data), 64'd20);
    issue_int = 1'b1;
    cycle();
    idle();
    check("t1_count", 64'(count), 64'd0);

    // wakeup latency
    disp(1, 6, 0, 7, 0, 1, 0, 33);
    cycle();
    idle();
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'hAB;
    check("wk_not_ready", 64'(ready_int), 64'd0);
    cycle();
    idle();
    check("wk_ready", 64'(ready_int), 64'd1);
    check("wk_rs1", 64'(issue_rs1_data), 64'hAB);
    issue_int = 1'b1;
    cycle();
    idle();

    // out-of-order selection
    disp(2, 8, 0, 2, 0, 1, 0, 1);
    cycle();
    disp(2, 9, 1, 0, 4, 1, 0, 5);
    cycle();
    idle();
    check("ooo_rd_young", 64'(issue_rd_tag), 64'd9);
    issue_int = 1'b1;
    cycle();
    idle();
    cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_data = 32'h77;
    cycle();
    idle();
    check("ooo_rd_old", 64'(issue_rd_tag), 64'd8);
    issue_int = 1'b1;
    cycle();
    idle();

    // full queue refuses dispatch even while issuing
    for (int i = 0; i < DEPTH; i++) begin
      disp(4, 20 + i, 1, 0, i, 1, 0, i + 1);
      cycle();
    end
    idle();
    check("full_flag", 64'(queue_full), 64'd1);
    disp(4, 30, 1, 0, 1, 1, 0, 2);
    issue_int = 1'b1;
    cycle();
    idle();
    check("full_count", 64'(count), 64'd3);

    // flush beats dispatch and issue
    flush = 1'b1; issue_int = 1'b1;
    disp(6, 40, 1, 0, 1, 1, 0, 2);
    cycle();
    idle();
    check("flush_count", 64'(count), 64'd0);
    check("flush_ready", 64'(ready_int), 64'd0);

    // dispatch bypass
    disp(5, 10, 1, 0, 1, 0, 9, 0);
    cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'h55;
    cycle();
    idle();
    check("byp_ready", 64'(ready_int), 64'd1);
    check("byp_rs2", 64'(issue_rs2_data), 64'h55);
    issue_int = 1'b1;
    cycle();
    idle();

    // randomized traffic in two load profiles
    for (int ph = 0; ph < 2; ph++) begin
      for (int n = 0; n < 2000; n++) begin
        rst   = ($urandom_range(0, 299) != 0);
        flush = ($urandom_range(0, 149) == 0);
        dispatch_valid = ($urandom_range(0, 99) < (ph == 0 ? 75 : 40));
        dispatch_opcode = OPC_W'($urandom);
        dispatch_rd_tag = TAG_W'($urandom);
        dispatch_rs1_valid = ($urandom_range(0, 2) == 0);
        dispatch_rs2_valid = ($urandom_range(0, 2) == 0);
        dispatch_rs1_tag = TAG_W'($urandom_range(0, 7));
        dispatch_rs2_tag = TAG_W'($urandom_range(0, 7));
        dispatch_rs1_data = $urandom;
        dispatch_rs2_data = $urandom;
        cdb_valid = $urandom_range(0, 1);
        cdb_tag = TAG_W'($urandom_range(0, 7));
        cdb_data = $urandom;
        issue_int = ($urandom_range(0, 99) < (ph == 0 ? 30 : 75));
        cycle();
      end
    end
    idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
